exec_dispatcher: RTL and testbench

Receiving end of the scheduler's output AXI-Stream. It accepts batched, conflict-free transactions and buffers them in order. Each transaction is issued to one of NUM_LANES execution lanes, but only when it has no RAW, WAW or WAR hazard against transactions still in flight. Lane completions release their dependency sets. Counters report throughput and stall causes.

---
 rtl/svm_sched_pkg.sv | 16 +
 rtl/txn_fifo.sv | 69 ++++++
 rtl/exec_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_exec_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_sched_pkg.sv
// Types and constants shared between the scheduler output stream and the dispatcher.
package svm_sched_pkg;

  localparam int PROGRAM_ID_W             = 64;
  localparam int MAX_DEPENDENCIES_DEFAULT = 256;

  typedef logic [MAX_DEPENDENCIES_DEFAULT-1:0] dep_vec_t;

  // One scheduler transaction, as carried on the AXI-Stream tdata fields.
  typedef struct packed {
    logic [PROGRAM_ID_W-1:0] program_id;
    dep_vec_t                read_deps;
    dep_vec_t                write_deps;
  } txn_t;

endpackage

// File: rtl/txn_fifo.sv
// Synchronous FIFO with a registered occupancy count. The head word is read
// straight from storage, so a word written this cycle is never visible at the
// read port until the next cycle.
module txn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the count gates every read, so stale words are never observed.
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/exec_dispatcher.sv
// In-order dispatcher: buffers incoming transactions and issues the head to the
// lowest idle lane once it has no RAW/WAW/WAR hazard against in-flight work.
module exec_dispatcher
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES = MAX_DEPENDENCIES_DEFAULT,
  parameter int NUM_LANES        = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [PROGRAM_ID_W-1:0]       s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_write_dependencies,
  output logic                          dispatch_valid,
  output logic [$clog2(NUM_LANES)-1:0]  dispatch_lane,
  output logic [PROGRAM_ID_W-1:0]       dispatch_programID,
  output logic [MAX_DEPENDENCIES-1:0]   dispatch_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]   dispatch_write_dependencies,
  input  logic [NUM_LANES-1:0]          lane_done,
  output logic [NUM_LANES-1:0]          lanes_busy,
  output logic                          protocol_error,
  output logic [31:0]                   txn_dispatched,
  output logic [31:0]                   txn_completed,
  output logic [31:0]                   hazard_stall_cycles,
  output logic [31:0]                   lane_stall_cycles
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int MD     = MAX_DEPENDENCIES;

  typedef struct packed {
    logic [PROGRAM_ID_W-1:0] program_id;
    logic [MD-1:0]           read_deps;
    logic [MD-1:0]           write_deps;
  } lane_txn_t;

  lane_txn_t                 in_txn, head_txn, disp_q, disp_d;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  logic [NUM_LANES-1:0]      busy_q, busy_d, done_ok;
  logic [MD-1:0]             lane_r_q [NUM_LANES];
  logic [MD-1:0]             lane_r_d [NUM_LANES];
  logic [MD-1:0]             lane_w_q [NUM_LANES];
  logic [MD-1:0]             lane_w_d [NUM_LANES];
  logic [MD-1:0]             inflight_r, inflight_w;
  logic [LANE_W-1:0]         sel_lane, disp_lane_q, disp_lane_d;
  logic                      head_valid, any_idle, hazard, issue, done_bad;
  logic                      disp_valid_q, disp_valid_d, perr_q, perr_d;
  logic [31:0]               done_cnt;
  logic [31:0]               n_disp_q, n_disp_d, n_comp_q, n_comp_d;
  logic [31:0]               n_hz_q, n_hz_d, n_ls_q, n_ls_d;

  assign in_txn = '{program_id: s_axis_tdata_owner_programID,
                    read_deps:  s_axis_tdata_read_dependencies,
                    write_deps: s_axis_tdata_write_dependencies};

  txn_fifo #(
    .WIDTH ($bits(lane_txn_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s_axis_tvalid),
    .wr_data (in_txn),
    .rd_en   (issue),
    .rd_data (head_txn),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  // Ready comes from the registered FIFO count only, never from the issue path.
  assign s_axis_tready = !fifo_full;
  assign head_valid    = !fifo_empty;
  assign any_idle      = !(&busy_q);
  assign done_ok       = lane_done & busy_q;
  assign done_bad      = |(lane_done & ~busy_q);
  assign issue         = head_valid && any_idle && !hazard;

  // Union of dependency sets held by busy lanes, then the hazard test on the head.
  always_comb begin
    inflight_r = '0;
    inflight_w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (busy_q[i]) begin
        inflight_r = inflight_r | lane_r_q[i];
        inflight_w = inflight_w | lane_w_q[i];
      end
    end
    hazard = (|(head_txn.write_deps & (inflight_r | inflight_w))) ||
             (|(head_txn.read_deps & inflight_w));
  end

  // Priority encoder: lowest-index idle lane.
  always_comb begin
    sel_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!busy_q[i]) sel_lane = LANE_W'(i);
    end
  end

  // Lane occupancy: completions release, issue claims a lane idle before the edge.
  always_comb begin
    busy_d   = busy_q & ~done_ok;
    lane_r_d = lane_r_q;
    lane_w_d = lane_w_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (done_ok[i]) begin
        lane_r_d[i] = '0;
        lane_w_d[i] = '0;
      end
    end
    if (issue) begin
      busy_d[sel_lane]   = 1'b1;
      lane_r_d[sel_lane] = head_txn.read_deps;
      lane_w_d[sel_lane] = head_txn.write_deps;
    end
  end

  // Dispatch output capture, error flag and statistics counters.
  always_comb begin
    disp_valid_d = issue;
    disp_lane_d  = issue ? sel_lane : disp_lane_q;
    disp_d       = issue ? head_txn : disp_q;
    perr_d       = perr_q | done_bad;
    done_cnt     = '0;
    for (int i = 0; i < NUM_LANES; i++) done_cnt = done_cnt + 32'(done_ok[i]);
    n_disp_d     = n_disp_q + 32'(issue);
    n_comp_d     = n_comp_q + done_cnt;
    n_ls_d       = n_ls_q + 32'(head_valid && !any_idle);
    n_hz_d       = n_hz_q + 32'(head_valid && any_idle && hazard);
  end

  // State registers; reset drops all buffered and in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_r_q[i] <= '0;
        lane_w_q[i] <= '0;
      end
      disp_valid_q <= 1'b0;
      disp_lane_q  <= '0;
      disp_q       <= '0;
      perr_q       <= 1'b0;
      n_disp_q     <= '0;
      n_comp_q     <= '0;
      n_hz_q       <= '0;
      n_ls_q       <= '0;
    end else begin
      busy_q       <= busy_d;
      lane_r_q     <= lane_r_d;
      lane_w_q     <= lane_w_d;
      disp_valid_q <= disp_valid_d;
      disp_lane_q  <= disp_lane_d;
      disp_q       <= disp_d;
      perr_q       <= perr_d;
      n_disp_q     <= n_disp_d;
      n_comp_q     <= n_comp_d;
      n_hz_q       <= n_hz_d;
      n_ls_q       <= n_ls_d;
    end
  end

  assign dispatch_valid              = disp_valid_q;
  assign dispatch_lane               = disp_lane_q;
  assign dispatch_programID          = disp_q.program_id;
  assign dispatch_read_dependencies  = disp_q.read_deps;
  assign dispatch_write_dependencies = disp_q.write_deps;
  assign lanes_busy                  = busy_q;
  assign protocol_error              = perr_q;
  assign txn_dispatched              = n_disp_q;
  assign txn_completed               = n_comp_q;
  assign hazard_stall_cycles         = n_hz_q;
  assign lane_stall_cycles           = n_ls_q;

endmodule

// File: tb/tb_exec_dispatcher.sv
// Scoreboard bench for exec_dispatcher: a queue/array reference model predicts
// dispatches and statistics; a monitor on the falling edge compares.
module tb_exec_dispatcher;
  import svm_sched_pkg::*;

  localparam int MD = MAX_DEPENDENCIES_DEFAULT;
  localparam int NL = 4;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [63:0]     s_id = '0;
  logic [MD-1:0]   s_r = '0, s_w = '0;
  logic            dispatch_valid;
  logic [1:0]      dispatch_lane;
  logic [63:0]     dispatch_programID;
  logic [MD-1:0]   dispatch_read_dependencies, dispatch_write_dependencies;
  logic [NL-1:0]   lane_done = '0;
  logic [NL-1:0]   lanes_busy;
  logic            protocol_error;
  logic [31:0]     txn_dispatched, txn_completed, hazard_stall_cycles, lane_stall_cycles;

  exec_dispatcher #(.MAX_DEPENDENCIES(MD), .NUM_LANES(NL), .FIFO_DEPTH(FD)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_r),
    .s_axis_tdata_write_dependencies (s_w),
    .dispatch_valid                  (dispatch_valid),
    .dispatch_lane                   (dispatch_lane),
    .dispatch_programID              (dispatch_programID),
    .dispatch_read_dependencies      (dispatch_read_dependencies),
    .dispatch_write_dependencies     (dispatch_write_dependencies),
    .lane_done                       (lane_done),
    .lanes_busy                      (lanes_busy),
    .protocol_error                  (protocol_error),
    .txn_dispatched                  (txn_dispatched),
    .txn_completed                   (txn_completed),
    .hazard_stall_cycles             (hazard_stall_cycles),
    .lane_stall_cycles               (lane_stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          lane;
    txn_t        t;
    int unsigned cyc;
  } exp_t;

  txn_t          m_fifo[$];
  exp_t          exp_q[$];
  bit [NL-1:0]   m_busy = '0;
  logic [MD-1:0] m_r [NL];
  logic [MD-1:0] m_w [NL];
  int unsigned   m_disp = 0, m_comp = 0, m_hz = 0, m_ls = 0;
  bit            m_perr = 1'b0;
  int unsigned   cyc = 0;
  bit            mon_en = 1'b0;

  task automatic model_clear();
    m_fifo.delete();
    exp_q.delete();
    m_busy = '0;
    for (int i = 0; i < NL; i++) begin m_r[i] = '0; m_w[i] = '0; end
    m_disp = 0; m_comp = 0; m_hz = 0; m_ls = 0; m_perr = 1'b0;
  endtask

  // Model step at each rising edge from pre-edge state and inputs.
  always @(posedge clk) begin
    logic [MD-1:0] ir, iw;
    int   idle;
    bit   have, hz, acc;
    if (rst_n) begin
      cyc++;
      ir = '0; iw = '0;
      for (int i = 0; i < NL; i++) if (m_busy[i]) begin ir |= m_r[i]; iw |= m_w[i]; end
      idle = -1;
      for (int i = 0; i < NL; i++) if (!m_busy[i] && idle < 0) idle = i;
      have = (m_fifo.size() > 0);
      hz   = 1'b0;
      if (have) hz = ((m_fifo[0].write_deps & (ir | iw)) != '0) || ((m_fifo[0].read_deps & iw) != '0);
      acc  = s_axis_tvalid && (m_fifo.size() < FD);
      if (have && idle < 0) m_ls++;
      if (have && idle >= 0 && hz) m_hz++;
      for (int i = 0; i < NL; i++) begin
        if (lane_done[i]) begin
          if (m_busy[i]) begin m_busy[i] = 1'b0; m_r[i] = '0; m_w[i] = '0; m_comp++; end
          else m_perr = 1'b1;
        end
      end
      if (have && idle >= 0 && !hz) begin
        exp_t e;
        e.t = m_fifo.pop_front();
        e.lane = idle;
        e.cyc = cyc;
        m_busy[idle] = 1'b1;
        m_r[idle] = e.t.read_deps;
        m_w[idle] = e.t.write_deps;
        m_disp++;
        exp_q.push_back(e);
      end
      if (acc) m_fifo.push_back('{program_id: s_id, read_deps: s_r, write_deps: s_w});
    end
  end

  // Monitor: compare DUT outputs against the model on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (mon_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && rst_n;
      check("dispatch_valid", dispatch_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        if (dispatch_valid) begin
          check("dispatch_lane", dispatch_lane, e.lane[1:0]);
          check("dispatch_id", dispatch_programID, e.t.program_id);
          check("dispatch_rd", dispatch_read_dependencies, e.t.read_deps);
          check("dispatch_wr", dispatch_write_dependencies, e.t.write_deps);
        end
      end
      check("lanes_busy", lanes_busy, m_busy);
      check("tready", s_axis_tready, m_fifo.size() < FD);
      check("protocol_error", protocol_error, m_perr);
      check("txn_dispatched", txn_dispatched, m_disp);
      check("txn_completed", txn_completed, m_comp);
      check("hazard_stall", hazard_stall_cycles, m_hz);
      check("lane_stall", lane_stall_cycles, m_ls);
    end
  end

  // ---------------- stimulus helpers (called at negedge+1) ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [MD-1:0] bitv(input int b);
    logic [MD-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [MD-1:0] rand_deps();
    logic [MD-1:0] v;
    v = '0;
    repeat ($urandom_range(0, 2)) v[$urandom_range(0, 11)] = 1'b1;
    return v;
  endfunction

  // Present a transaction and hold it until accepted; leaves tvalid asserted.
  task automatic send(input logic [63:0] id, input logic [MD-1:0] r, input logic [MD-1:0] w);
    bit got;
    lane_done = '0;
    s_axis_tvalid = 1'b1;
    s_id = id; s_r = r; s_w = w;
    for (int k = 0; k < 200; k++) begin
      got = s_axis_tready;
      step();
      if (got) return;
    end
    check("send_timeout", got, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    s_axis_tvalid = 1'b0;
    lane_done = '0;
    repeat (n) step();
  endtask

  task automatic done(input logic [NL-1:0] mask);
    s_axis_tvalid = 1'b0;
    lane_done = mask;
    step();
    lane_done = '0;
  endtask

  // Complete every busy lane until nothing is buffered or in flight.
  task automatic drain();
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (m_busy == '0 && m_fifo.size() == 0 && exp_q.size() == 0) break;
      lane_done = m_busy;
      step();
    end
    lane_done = '0;
    check("drain_idle", lanes_busy, '0);
    step();
  endtask

  initial begin
    bit last_hs;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_tready", s_axis_tready, 1'b1);
    check("reset_busy", lanes_busy, '0);
    check("reset_valid", dispatch_valid, 1'b0);
    check("reset_disp_cnt", txn_dispatched, '0);
    mon_en = 1'b1;

    // Single transaction: lane 0, two-cycle latency.
    send(64'h1, bitv(3), bitv(5));
    idle_cycles(3);
    check("single_busy", lanes_busy, 4'b0001);
    check("single_count", txn_dispatched, 32'd1);
    done(4'b0001);
    idle_cycles(2);

    // Four disjoint back-to-back, then a fifth stalls on lanes.
    for (int i = 0; i < 4; i++) send(64'h10 + 64'(i), bitv(10 + i), bitv(20 + i));
    send(64'h20, bitv(40), bitv(41));
    idle_cycles(5);
    check("four_busy", lanes_busy, 4'b1111);
    done(4'b0100);
    idle_cycles(3);
    drain();

    // RAW, WAW, WAR against lane 0.
    for (int kind = 0; kind < 3; kind++) begin
      if (kind == 2) send(64'h30, bitv(7), '0);
      else           send(64'h30, '0, bitv(7));
      idle_cycles(3);
      if (kind == 0) send(64'h31, bitv(7), '0);
      else           send(64'h31, '0, bitv(7));
      idle_cycles(5);
      check("hazard_hold", lanes_busy, 4'b0001);
      done(4'b0001);
      idle_cycles(3);
      drain();
    end

    // In-order blocking behind a hazarded head, and FIFO full.
    send(64'h40, '0, bitv(7));
    idle_cycles(2);
    send(64'h41, bitv(7), '0);
    send(64'h42, bitv(50), bitv(51));
    send(64'h43, bitv(52), bitv(53));
    send(64'h44, bitv(54), bitv(55));
    idle_cycles(2);
    check("full_tready", s_axis_tready, 1'b0);
    done(4'b0001);
    idle_cycles(6);
    drain();

    // Completion on an idle lane, then a double completion.
    done(4'b1000);
    idle_cycles(1);
    check("perr_set", protocol_error, 1'b1);
    send(64'h50, bitv(60), bitv(61));
    send(64'h51, bitv(62), bitv(63));
    idle_cycles(3);
    done(4'b0011);
    idle_cycles(2);
    check("perr_sticky", protocol_error, 1'b1);

    // Randomized traffic with random completions on busy lanes.
    last_hs = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!s_axis_tvalid || last_hs) begin
        s_axis_tvalid = ($urandom_range(0, 9) < 6);
        s_id = {$urandom, $urandom};
        s_r = rand_deps();
        s_w = rand_deps();
      end
      lane_done = m_busy & NL'($urandom);
      last_hs = s_axis_tvalid && s_axis_tready;
      step();
    end
    drain();

    // Reset with two lanes busy and three buffered entries.
    send(64'h60, '0, bitv(9));
    send(64'h61, '0, bitv(70));
    send(64'h62, bitv(9), '0);
    send(64'h63, bitv(80), '0);
    send(64'h64, bitv(81), '0);
    idle_cycles(2);
    check("pre_reset_busy", lanes_busy, 4'b0011);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_busy", lanes_busy, '0);
    check("rst_valid", dispatch_valid, 1'b0);
    check("rst_disp_cnt", txn_dispatched, '0);
    check("rst_hz_cnt", hazard_stall_cycles, '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_tready", s_axis_tready, 1'b1);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
